// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling ratio and
// the baud divider calculation used by both the receiver and transmitter.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [3:0] VOTE_FIRST = 4'd7;
  localparam logic [3:0] VOTE_MID   = 4'd8;
  localparam logic [3:0] VOTE_LAST  = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversampling tick generator: one tick every DIV clocks, phase-restartable so
// ticks line up with the detected start edge.
module baud_tick_gen #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic RST,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  // Ticks fire mid-count so each sample sits well clear of the restart point.
  localparam logic [CNT_W-1:0] TICK_AT  = CNT_W'(DIV / 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || cnt_q == CNT_LAST) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == TICK_AT);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x tick-driven FSM with 3-sample
// majority vote, and a valid/ready holding register that reports drops.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       uart_rx_line,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  logic       sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic       armed_q, armed_d;
  logic [1:0] flush_q, flush_d;
  rx_state_t  state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [1:0] vote_q, vote_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;

  logic       tick, restart, decide, bit_val, deliver;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .RST     (RST),
    .restart (restart),
    .tick    (tick)
  );

  // Arming waits until the sync chain holds real line samples, so a line
  // held low across reset release never looks like a start edge.
  always_comb begin
    sync1_d = uart_rx_line;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    flush_d = (flush_q == 2'd2) ? flush_q : flush_q + 2'd1;
    armed_d = armed_q | ((flush_q == 2'd2) & sync2_q);
  end

  assign restart = (state_q == IDLE) && armed_q && prev_q && !sync2_q;
  assign decide  = tick && (tick_cnt_q == VOTE_LAST);
  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & sync2_q) | (vote_q[1] & sync2_q);

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    vote_d      = vote_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;

    if (tick && state_q != IDLE && state_q != BREAK) begin
      tick_cnt_d = (tick_cnt_q == TICK_LAST) ? 4'd0 : tick_cnt_q + 4'd1;
      if (tick_cnt_q == VOTE_FIRST) vote_d[0] = sync2_q;
      if (tick_cnt_q == VOTE_MID)   vote_d[1] = sync2_q;
    end

    unique case (state_q)
      IDLE: begin
        if (restart) begin
          state_d    = START;
          tick_cnt_d = 4'd0;
        end
      end
      START: begin
        if (decide) begin
          bit_idx_d = 3'd0;
          state_d   = bit_val ? IDLE : DATA;
        end
      end
      DATA: begin
        if (decide) begin
          shift_d   = {bit_val, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          if (bit_val) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        if (sync2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A delivery may overlap a transfer of the held byte; only a full,
  // unaccepted holding register drops the new byte.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      armed_q     <= 1'b0;
      flush_q     <= 2'd0;
      state_q     <= IDLE;
      tick_cnt_q  <= 4'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      vote_q      <= 2'b00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      armed_q     <= armed_d;
      flush_q     <= flush_d;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      vote_q      <= vote_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, hand-written corner
// sequences and randomized frames against a frame-level reference model.
module tb_uart_rx;

  localparam int BITCLK  = 432;
  localparam int LAT_NOM = 4148;

  logic       clk = 1'b0;
  logic       RST;
  logic       uart_rx_line;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] got_q[$];
  int ferr_cnt = 0, ovr_cnt = 0, valid_hi_cnt = 0, valid_rise_cyc = -1;
  logic valid_prev = 1'b0;

  int got_base, ferr_base, ovr_base, vhi_base, start_cyc;

  typedef struct {
    logic [7:0] data;
    int         bitclk;
    logic       stop_bit;
    int         hold_low;
    int         exp_bytes;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;
  vec_t vecs[3];

  logic [7:0] m_data;
  logic       m_valid;
  int         m_ovr, m_ferr;
  logic [7:0] m_xfer_q[$];

  uart_rx dut (
    .clk          (clk),
    .RST          (RST),
    .uart_rx_line (uart_rx_line),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observe handshake transfers and pulses away from the active edge.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (rx_valid && !valid_prev) valid_rise_cyc = cyc;
    if (rx_valid) valid_hi_cnt++;
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    valid_prev = rx_valid;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    n_cmp++;
    if (actual < lo || actual > hi) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic markMon();
    got_base  = got_q.size();
    ferr_base = ferr_cnt;
    ovr_base  = ovr_cnt;
    vhi_base  = valid_hi_cnt;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int bitclk, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      uart_rx_line = f[i];
      idle(bitclk);
    end
  endtask

  initial begin
    logic [7:0] b;
    int         bc;
    logic       good, rdy;

    vecs[0] = '{8'h48, BITCLK, 1'b1, 0,    1, 8'h48, 0};
    vecs[1] = '{8'hA5, BITCLK, 1'b0, 2000, 0, 8'h00, 1};
    vecs[2] = '{8'h3C, BITCLK, 1'b1, 0,    1, 8'h3C, 0};

    $display("[TB] uart_rx bench start");
    RST = 1'b1;
    uart_rx_line = 1'b1;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    idle(3);
    checkOutput("reset_rx_data", rx_data, 8'h00);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_frame_err", frame_err, 0);
    checkOutput("reset_overrun", overrun, 0);
    checkOutput("reset_busy", busy, 0);
    RST = 1'b0;
    idle(20);

    for (int v = 0; v < 3; v++) begin
      markMon();
      applyStimulus(vecs[v].data, vecs[v].bitclk, vecs[v].stop_bit);
      if (vecs[v].hold_low > 0) idle(vecs[v].hold_low);
      uart_rx_line = 1'b1;
      idle(40);
      checkOutput($sformatf("vec%0d_bytes", v), got_q.size() - got_base, vecs[v].exp_bytes);
      if (vecs[v].exp_bytes > 0 && got_q.size() > got_base)
        checkOutput($sformatf("vec%0d_data", v), got_q[got_base], vecs[v].exp_data);
      checkOutput($sformatf("vec%0d_valid_cycles", v), valid_hi_cnt - vhi_base, vecs[v].exp_bytes);
      checkOutput($sformatf("vec%0d_frame_err", v), ferr_cnt - ferr_base, vecs[v].exp_ferr);
      checkOutput($sformatf("vec%0d_overrun", v), ovr_cnt - ovr_base, 0);
      if (vecs[v].exp_bytes > 0)
        checkRange($sformatf("vec%0d_latency", v), valid_rise_cyc - start_cyc, LAT_NOM - 2, LAT_NOM + 2);
    end

    markMon();
    uart_rx_line = 1'b0;
    idle(50);
    checkOutput("glitch_busy_high", busy, 1);
    idle(50);
    uart_rx_line = 1'b1;
    idle(200);
    checkOutput("glitch_busy_clear", busy, 0);
    checkOutput("glitch_no_valid", valid_hi_cnt - vhi_base, 0);
    checkOutput("glitch_no_ferr", ferr_cnt - ferr_base, 0);

    markMon();
    rx_ready = 1'b0;
    applyStimulus(8'h11, BITCLK, 1'b1);
    idle(20);
    applyStimulus(8'h22, BITCLK, 1'b1);
    idle(20);
    checkOutput("ovr_held_data", rx_data, 8'h11);
    checkOutput("ovr_valid_held", rx_valid, 1);
    checkOutput("ovr_pulses", ovr_cnt - ovr_base, 1);
    checkOutput("ovr_no_transfer", got_q.size() - got_base, 0);
    rx_ready = 1'b1;
    idle(3);
    checkOutput("ovr_transfer_count", got_q.size() - got_base, 1);
    if (got_q.size() > got_base) checkOutput("ovr_transfer_data", got_q[got_base], 8'h11);
    checkOutput("ovr_valid_cleared", rx_valid, 0);

    // 0x7F: bits 0..6 high, bit 7 low; reset lands inside bit 7.
    markMon();
    uart_rx_line = 1'b0;
    idle(BITCLK);
    uart_rx_line = 1'b1;
    idle(7 * BITCLK);
    uart_rx_line = 1'b0;
    idle(100);
    checkOutput("rst_busy_before", busy, 1);
    RST = 1'b1;
    idle(3);
    RST = 1'b0;
    idle(20);
    checkOutput("rst_rx_data", rx_data, 8'h00);
    checkOutput("rst_rx_valid", rx_valid, 0);
    checkOutput("rst_busy", busy, 0);
    idle(BITCLK - 123);
    uart_rx_line = 1'b1;
    idle(BITCLK + 300);
    checkOutput("rst_no_bytes", valid_hi_cnt - vhi_base, 0);
    checkOutput("rst_no_ferr", ferr_cnt - ferr_base, 0);
    checkOutput("rst_no_ovr", ovr_cnt - ovr_base, 0);
    applyStimulus(8'h55, BITCLK, 1'b1);
    idle(40);
    checkOutput("rst_next_count", got_q.size() - got_base, 1);
    if (got_q.size() > got_base) checkOutput("rst_next_data", got_q[got_base], 8'h55);

    markMon();
    for (int i = 0; i < 10; i++) applyStimulus(8'(i), 423, 1'b1);
    idle(100);
    checkOutput("b2b_count", got_q.size() - got_base, 10);
    for (int i = 0; i < 10; i++)
      if (got_base + i < got_q.size())
        checkOutput($sformatf("b2b_data%0d", i), got_q[got_base + i], 8'(i));
    checkOutput("b2b_ferr", ferr_cnt - ferr_base, 0);
    checkOutput("b2b_ovr", ovr_cnt - ovr_base, 0);

    // Frame-level model: holding register, transfers while ready, drops when full.
    markMon();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ovr   = 0;
    m_ferr  = 0;
    m_xfer_q.delete();
    for (int k = 0; k < 2; k++) begin
      b    = 8'($urandom);
      bc   = $urandom_range(423, 441);
      good = ($urandom_range(0, 3) != 0);
      rdy  = 1'($urandom_range(0, 1));
      rx_ready = rdy;
      if (rdy && m_valid) begin
        m_xfer_q.push_back(m_data);
        m_valid = 1'b0;
      end
      applyStimulus(b, bc, good);
      uart_rx_line = 1'b1;
      idle($urandom_range(40, 200));
      if (good) begin
        if (!m_valid) begin
          m_data  = b;
          m_valid = 1'b1;
        end else begin
          m_ovr++;
        end
      end else begin
        m_ferr++;
      end
      if (rdy && m_valid) begin
        m_xfer_q.push_back(m_data);
        m_valid = 1'b0;
      end
    end
    rx_ready = 1'b1;
    idle(3);
    if (m_valid) begin
      m_xfer_q.push_back(m_data);
      m_valid = 1'b0;
    end
    checkOutput("rnd_count", got_q.size() - got_base, m_xfer_q.size());
    for (int i = 0; i < m_xfer_q.size(); i++)
      if (got_base + i < got_q.size())
        checkOutput($sformatf("rnd_data%0d", i), got_q[got_base + i], m_xfer_q[i]);
    checkOutput("rnd_ferr", ferr_cnt - ferr_base, m_ferr);
    checkOutput("rnd_ovr", ovr_cnt - ovr_base, m_ovr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Byte-oriented UART receiver, 8N1, 16x oversampled, with valid/ready output handshake. It is the receiving end of the temperature telemetry link: it decodes the serial line driven by the transmitter stage, including the 7-bit temperature value sent as one byte with MSB 0, and hands bytes to on-chip consumers. It also serves as the loopback checker for the transmit path.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock in Hz.
- `BAUD`, default 115200: line rate.
- `OVERSAMPLE`, default 16: ticks per bit. Fixed at 16; other values are not supported.
- `clk`, input, 1: system clock; all logic on rising edge.
- `RST`, input, 1: synchronous, active-high reset.
- `uart_rx_line`, input, 1: asynchronous serial input; idle high.
- `rx_data`, output, 8: received byte. Valid while `rx_valid` is high.
- `rx_valid`, output, 1: byte available. Held until it is accepted.
- `rx_ready`, input, 1: consumer accept. A transfer occurs when `rx_valid && rx_ready`.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `overrun`, output, 1: one-cycle pulse when a byte is dropped.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- Input path is a 2-flop synchronizer followed by an edge-detect register. All three flops reset to 1.
- Tick generator:
  - `DIV = CLK_FREQ/(BAUD*16)`, integer truncated. The default gives 27 clocks per tick, 432 clocks per bit.
  - The counter restarts at 0 on start-edge detection, so ticks are phase-aligned to the frame.
- Arming:
  - After reset the receiver is unarmed.
  - It arms once the synchronized line is seen high.
  - A line held low through reset release produces no frame.
- States:
  - IDLE: armed, waiting for a synced 1→0 transition. On the edge, go to START with tick count 0.
  - START: at tick 8, majority-vote ticks 7,8,9 (decision at tick 9).
    - Result 1: false start. Return to IDLE with nothing reported.
    - Result 0: go to DATA.
  - DATA: 8 bits, LSB first. Each bit is a 16-tick window decided by majority of ticks 7,8,9 and shifted into the shift register. After bit 7, go to STOP.
  - STOP: majority vote at ticks 7–9.
    - 1: deliver the byte and go to IDLE.
    - 0: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for the synced line high, then IDLE. A held-low break yields exactly one `frame_err` and no bytes.
- Delivery:
  - If `rx_valid` is 0, or it is 1 with `rx_ready` 1 in the same cycle, load `rx_data` and set `rx_valid`.
  - Otherwise pulse `overrun`; `rx_data` keeps the old byte and the new byte is dropped.
- `rx_valid` clears on the cycle after a transfer, unless a new byte loads in that same cycle.
- Reset mid-frame: the FSM returns to IDLE unarmed and the partial byte is lost. No `frame_err` or `overrun` is produced.

## Timing
- Reset values:
  - `rx_data` 0x00; `rx_valid`, `frame_err`, `overrun`, `busy` all 0.
  - FSM in IDLE and unarmed; sync flops 1; tick counter 0.
- Synchronizer latency is 2 cycles plus 1 cycle of edge detect.
- `rx_valid` rises at tick 10 of the stop bit: about 9.6 bit periods after the line's falling edge, which is 4148 ±2 clocks at the defaults.
- `frame_err` and `overrun` are single-cycle pulses in that same cycle.
- Back-to-back frames: a new start edge is accepted from the first IDLE cycle after stop-bit delivery. This tolerates senders up to ~3% fast.
- Tick counter: 0..15 per bit; the bit index wraps 0..7. The clock divider counts 0..DIV-1 and wraps.

## Structure
- Package `uart_pkg` holds:
  - `rx_state_t` enum: IDLE, START, DATA, STOP, BREAK.
  - `OVERSAMPLE` constant.
  - `function calc_div(clk_freq, baud)`, shared with the transmitter.
- Sub-module `baud_tick_gen`:
  - Parameter `DIV`.
  - Ports `clk`, `RST`, `restart`, `tick`.
  - Reused by the transmitter.
- The majority vote and FSM live in `uart_rx`.

## Test plan
- Frame 0x48 (temperature 72) at 115200 with `rx_ready` tied 1:
  - `rx_data` = 0x48 and a one-cycle `rx_valid`, 4148 ±2 clocks after the start edge.
  - No error pulses.
- Low glitch of 100 clocks on an idle line: no `rx_valid`; `busy` returns to 0 before clock 300.
- Frame 0xA5 with the stop bit driven low, then line held low 2000 clocks, then high:
  - Exactly one `frame_err`, no `rx_valid`.
  - A subsequent 0x3C is received correctly.
- `rx_ready` held 0, frames 0x11 then 0x22:
  - `rx_data` stays 0x11 and `overrun` pulses once.
  - Raising `rx_ready` transfers 0x11, then `rx_valid` = 0.
- Assert `RST` mid-DATA of 0x7F with the line low during release:
  - All outputs return to reset values.
  - No byte from the remainder of that frame.
  - Next clean frame 0x55 is received.
- Ten back-to-back frames 0x00..0x09, zero idle gap, sender baud +2%: all ten received in order with no errors.
